// File: rtl/accum_relu_compress.sv
`default_nettype none
// ============================================================================
// Module   : accum_relu_compress
// Purpose  : Snapshot the accumulator grid, ReLU/shift/saturate each entry and
//            stream the non-zero results as {pos, val} words with a count.
// Revision : 1.0 - initial release
// ============================================================================
module accum_relu_compress #(
  parameter int ACC_W = 20,
  parameter int GRID  = 12,
  parameter int OUT_W = 8,
  parameter int SHIFT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [ACC_W*GRID*GRID-1:0] accum_in,
  input  logic [4:0]                 limit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7+OUT_W:0]           out_data,
  output logic [7:0]                 nz_count,
  output logic                       busy,
  output logic                       done
);

  localparam int c_entries = GRID * GRID;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     r_state;
  logic [ACC_W*c_entries-1:0] r_snap;
  logic [3:0]                 r_lim;
  logic [3:0]                 r_row;
  logic [3:0]                 r_col;
  logic                       r_valid;
  logic [7+OUT_W:0]           r_data;
  logic [7:0]                 r_nz;
  logic                       r_busy;
  logic                       r_done;

  logic                       w_free;
  logic [3:0]                 w_lim_in;
  logic [7:0]                 w_idx;
  logic [7:0]                 w_pos;
  logic signed [ACC_W-1:0]    w_acc;
  logic signed [ACC_W-1:0]    w_shr;
  logic [OUT_W-1:0]           w_q;
  logic                       w_last_col;
  logic                       w_last_row;

  assign w_free     = !r_valid || out_ready;
  assign w_lim_in   = (limit > 5'd12) ? 4'd12 : limit[3:0];
  assign w_idx      = 8'(r_row) * 8'(GRID) + 8'(r_col);
  // Dense output position uses the active window width, not the grid pitch.
  assign w_pos      = 8'(r_row) * 8'(r_lim) + 8'(r_col);
  assign w_acc      = r_snap[w_idx*ACC_W +: ACC_W];
  assign w_shr      = w_acc >>> SHIFT;
  assign w_last_col = (r_col == r_lim - 4'd1);
  assign w_last_row = (r_row == r_lim - 4'd1);

  always_comb begin
    w_q = '0;
    if (!w_acc[ACC_W-1]) begin
      if (|w_shr[ACC_W-1:OUT_W]) w_q = '1;
      else                       w_q = w_shr[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_snap  <= '0;
      r_lim   <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_nz    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_valid && out_ready) r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_snap  <= accum_in;
            r_lim   <= w_lim_in;
            r_nz    <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_busy  <= 1'b1;
            r_state <= (w_lim_in == 4'd0) ? S_DONE : S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_free) begin
            if (w_q != '0) begin
              r_valid <= 1'b1;
              r_data  <= {w_pos, w_q};
              r_nz    <= r_nz + 8'd1;
            end
            if (w_last_col) begin
              r_col <= '0;
              if (w_last_row) r_state <= S_FLUSH;
              else            r_row   <= r_row + 4'd1;
            end else begin
              r_col <= r_col + 4'd1;
            end
          end
        end
        S_FLUSH: begin
          if (w_free) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign nz_count  = r_nz;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_accum_relu_compress.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_relu_compress
// Purpose  : Directed self-checking bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_relu_compress;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [2879:0] accum_in = '0;
  logic [4:0]   limit = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [15:0]  out_data;
  logic [7:0]   nz_count;
  logic         busy;
  logic         done;

  accum_relu_compress dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .accum_in (accum_in),
    .limit    (limit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .nz_count (nz_count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int                 n_cmp = 0;
  int                 n_err = 0;
  logic signed [19:0] tb_snap [144];
  logic [15:0]        exp_q[$];
  logic [15:0]        got_q[$];
  int                 exp_cnt = 0;
  int                 done_cnt = 0;
  bit                 mon_en = 1'b0;
  bit                 prev_stall = 1'b0;
  logic [15:0]        prev_data = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clear_snap();
    for (int k = 0; k < 144; k++) tb_snap[k] = '0;
  endtask

  task automatic pack_snap();
    for (int k = 0; k < 144; k++) accum_in[20*k +: 20] = tb_snap[k];
  endtask

  // Reference: ReLU, divide by 16, clamp to 255, keep non-zero in raster order.
  task automatic build_model(input int lim_in);
    int l;
    l = (lim_in > 12) ? 12 : lim_in;
    exp_q.delete();
    exp_cnt = 0;
    for (int r = 0; r < l; r++) begin
      for (int c = 0; c < l; c++) begin
        int a;
        int v;
        a = int'(tb_snap[r*12+c]);
        v = (a > 0) ? a / 16 : 0;
        if (v > 255) v = 255;
        if (v != 0) begin
          logic [7:0] p;
          logic [7:0] q;
          p = 8'(r*l + c);
          q = 8'(v);
          exp_q.push_back({p, q});
          exp_cnt++;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && reset) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("word", 32'(out_data), 32'(exp_q.pop_front()));
        end
        got_q.push_back(out_data);
      end
      if (done) begin
        done_cnt++;
        chk("done_drained", 32'(exp_q.size()), 32'd0);
        chk("done_nz", 32'(nz_count), 32'(exp_cnt));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic do_scan(input int lim_in, input int stall_len, input int extra_at,
                         output int done_cyc, output int first_cyc);
    int  cyc;
    int  stall_cnt;
    bit  stall_done;
    build_model(lim_in);
    got_q.delete();
    done_cnt   = 0;
    first_cyc  = -1;
    stall_cnt  = 0;
    stall_done = 1'b0;
    out_ready  = 1'b1;
    pack_snap();
    limit  = 5'(lim_in);
    start  = 1'b1;
    mon_en = 1'b1;
    cyc    = 0;
    while (!done && cyc < 600) begin
      @(posedge clk);
      #1;
      cyc++;
      start = 1'b0;
      if (cyc == 1) chk("busy_after_start", 32'(busy), 32'd1);
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (cyc == extra_at) begin
        start    = 1'b1;
        limit    = 5'd3;
        accum_in = {144{20'h00FF0}};
      end
      if (stall_len > 0 && !stall_done) begin
        if (stall_cnt > 0) begin
          stall_cnt--;
          if (stall_cnt == 0) begin
            out_ready  = 1'b1;
            stall_done = 1'b1;
          end
        end else if (out_valid) begin
          out_ready = 1'b0;
          stall_cnt = stall_len;
        end
      end
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
    done_cyc = cyc;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", 32'(done_cnt), 32'd1);
    chk("nz_hold", 32'(nz_count), 32'(exp_cnt));
    chk("busy_idle", 32'(busy), 32'd0);
    mon_en = 1'b0;
  endtask

  initial begin
    int dc;
    int fc;
    clear_snap();
    pack_snap();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_nz", 32'(nz_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // All zero, full window
    clear_snap();
    do_scan(12, 0, -1, dc, fc);
    chk("t1_words", 32'(got_q.size()), 32'd0);
    chk("t1_within_147", 32'(dc <= 147), 32'd1);
    chk("t1_nz", 32'(nz_count), 32'd0);

    // Single entry at position 0
    clear_snap();
    tb_snap[0] = 20'h00100;
    do_scan(12, 0, -1, dc, fc);
    chk("t2_nwords", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chk("t2_word", 32'(got_q[0]), 32'h0010);
    chk("t2_first_latency", 32'(fc), 32'd2);
    chk("t2_nz", 32'(nz_count), 32'd1);

    // Negative skipped, large positive saturates
    clear_snap();
    tb_snap[5]  = 20'hFFFFF;
    tb_snap[13] = 20'h7FFFF;
    do_scan(12, 0, -1, dc, fc);
    chk("t3_nwords", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chk("t3_word", 32'(got_q[0]), 32'h0DFF);

    // Reduced window: dense position, entry outside the window dropped
    clear_snap();
    tb_snap[12] = 20'h00050;
    tb_snap[11] = 20'h00FF0;
    do_scan(10, 0, -1, dc, fc);
    chk("t4_nwords", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chk("t4_word", 32'(got_q[0]), 32'h0A05);

    // Backpressure for 5 cycles after the first word
    clear_snap();
    tb_snap[0] = 20'h00100;
    tb_snap[1] = 20'h00200;
    tb_snap[2] = 20'h00030;
    do_scan(12, 5, -1, dc, fc);
    chk("t5_nwords", 32'(got_q.size()), 32'd3);
    if (got_q.size() >= 3) begin
      chk("t5_word0", 32'(got_q[0]), 32'h0010);
      chk("t5_word1", 32'(got_q[1]), 32'h0120);
      chk("t5_word2", 32'(got_q[2]), 32'h0203);
    end
    chk("t5_nz", 32'(nz_count), 32'd3);

    // limit of zero: done two cycles after start, nothing emitted
    clear_snap();
    tb_snap[0] = 20'h00100;
    do_scan(0, 0, -1, dc, fc);
    chk("lim0_latency", 32'(dc), 32'd2);
    chk("lim0_words", 32'(got_q.size()), 32'd0);
    chk("lim0_nz", 32'(nz_count), 32'd0);

    // limit above 12 clamps; last grid corner saturates
    clear_snap();
    tb_snap[143] = 20'h01000;
    do_scan(20, 0, -1, dc, fc);
    chk("clamp_nwords", 32'(got_q.size()), 32'd1);
    if (got_q.size() >= 1) chk("clamp_word", 32'(got_q[0]), 32'h8FFF);

    // Abort a scan with reset, then run a fresh one with an ignored restart
    clear_snap();
    for (int k = 0; k < 30; k++) tb_snap[k] = 20'h00100;
    pack_snap();
    limit = 5'd12;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'd0);
    chk("abort_data", 32'(out_data), 32'd0);
    chk("abort_nz", 32'(nz_count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    clear_snap();
    tb_snap[50]  = 20'h00300;
    tb_snap[100] = 20'h00050;
    do_scan(12, 0, 10, dc, fc);
    chk("t6_nwords", 32'(got_q.size()), 32'd2);
    if (got_q.size() >= 2) begin
      chk("t6_word0", 32'(got_q[0]), 32'h3230);
      chk("t6_word1", 32'(got_q[1]), 32'h6405);
    end
    chk("t6_nz", 32'(nz_count), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
